// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 matrix keypad scanner.
// Key indices: 0-9 are digits, 10 is '*', 11 is '#'.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Row-major: KEY_MAP[row][col] is the key index under that crossing.
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'd1,     4'd2, 4'd3},
    '{4'd4,     4'd5, 4'd6},
    '{4'd7,     4'd8, 4'd9},
    '{KEY_STAR, 4'd0, KEY_HASH}
  };

endpackage

// File: rtl/keypad_debounce_sync.sv
// Two-flop synchroniser for the asynchronous column returns, plus the
// scan tick generator that paces row dwell and column sampling.
module keypad_debounce_sync #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] col_n,
  output logic [2:0] col_s,
  output logic       tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] tick_cnt;
  logic [2:0]    col_meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      col_meta <= 3'b111;
      col_s    <= 3'b111;
    end else begin
      col_meta <= col_n;
      col_s    <= col_meta;
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CW'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: rotates the active-low row drive, decodes a single
// low column, debounces press and release, and holds a one-hot key vector.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [3:0]  row_n,
  input  logic [2:0]  col_n,
  output logic [11:0] key_onehot,
  output logic [3:0]  key_code,
  output logic        key_press,
  output state_t      state_dbg
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);

  logic [2:0] col_s;
  logic       tick;

  keypad_debounce_sync #(.SCAN_DIV(SCAN_DIV)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .col_n   (col_n),
    .col_s   (col_s),
    .tick    (tick)
  );

  state_t        state, state_nxt;
  logic [1:0]    row_idx, row_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [11:0]   onehot_nxt;
  logic [3:0]    code_nxt;
  logic          press_nxt;

  // Two or three low columns are ghosting and decode as no key.
  logic       single;
  logic [1:0] col_idx;
  logic [3:0] dec_code;

  always_comb begin
    single  = 1'b0;
    col_idx = 2'd0;
    case (col_s)
      3'b110:  begin single = 1'b1; col_idx = 2'd0; end
      3'b101:  begin single = 1'b1; col_idx = 2'd1; end
      3'b011:  begin single = 1'b1; col_idx = 2'd2; end
      default: begin single = 1'b0; col_idx = 2'd0; end
    endcase
    dec_code = KEY_MAP[row_idx][col_idx];
  end

  always_comb begin
    state_nxt  = state;
    row_nxt    = row_idx;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    onehot_nxt = key_onehot;
    code_nxt   = key_code;
    press_nxt  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (single) begin
            cand_nxt = dec_code;
            if (DEBOUNCE_TICKS == 1) begin
              state_nxt  = HELD;
              cnt_nxt    = '0;
              onehot_nxt = 12'b1 << dec_code;
              code_nxt   = dec_code;
              press_nxt  = 1'b1;
            end else begin
              state_nxt = DEBOUNCE;
              cnt_nxt   = DW'(1);
            end
          end else begin
            row_nxt = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (single && (dec_code == cand)) begin
            if (cnt == DB_LAST) begin
              state_nxt  = HELD;
              cnt_nxt    = '0;
              onehot_nxt = 12'b1 << cand;
              code_nxt   = cand;
              press_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt + DW'(1);
            end
          end else begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
            row_nxt   = row_idx + 2'd1;
          end
        end
        HELD: begin
          // In HELD the counter tracks consecutive fully-released samples.
          if (col_s == 3'b111) begin
            if (cnt == DB_LAST) begin
              state_nxt  = SCAN;
              cnt_nxt    = '0;
              onehot_nxt = '0;
              code_nxt   = '0;
              row_nxt    = row_idx + 2'd1;
            end else begin
              cnt_nxt = cnt + DW'(1);
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= SCAN;
      row_idx    <= 2'd0;
      cand       <= '0;
      cnt        <= '0;
      key_onehot <= '0;
      key_code   <= '0;
      key_press  <= 1'b0;
    end else begin
      state      <= state_nxt;
      row_idx    <= row_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      key_onehot <= onehot_nxt;
      key_code   <= code_nxt;
      key_press  <= press_nxt;
    end
  end

  assign row_n     = ~(4'b0001 << row_idx);
  assign state_dbg = state;

endmodule
